// File: rtl/write_engine_pkg.sv
// write_engine_pkg
// Shared types and constants for the memcpy write path: WED, command, data-line,
// response and buffer-status records, the write engine FSM states, the staged
// line entry, and the element-count to cache-line-count helper.
package write_engine_pkg;

   localparam int ADDR_W          = 64;
   localparam int DATA_W          = 512;   // one half-line, 64B
   localparam int ARRAY_SIZE_BITS = 32;
   localparam int CU_ID_W         = 8;
   localparam int CMD_W           = 13;
   localparam int SIZE_W          = 12;
   localparam int RESP_W          = 8;

   localparam int CACHELINE_BYTES = 128;
   localparam int ELEMS_PER_LINE  = 32;    // 4B elements per 128B line
   localparam int LINE_SHIFT      = 5;

   localparam logic [CU_ID_W-1:0] DATA_WRITE_CONTROL_ID = 8'h14;
   localparam logic [CMD_W-1:0]   WRITE_MI              = 13'h0D70;
   localparam logic [RESP_W-1:0]  RSP_DONE              = 8'h00;
   localparam logic [RESP_W-1:0]  RSP_FAILED            = 8'h03;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      STREAM,
      DRAIN,
      DONE
   } write_engine_state_t;

   typedef struct packed {
      logic                       valid;
      logic [ADDR_W-1:0]          array_send;
      logic [ADDR_W-1:0]          array_receive;
      logic [ARRAY_SIZE_BITS-1:0] size_send;
   } wed_interface_t;

   typedef struct packed {
      logic               valid;
      logic [CMD_W-1:0]   command;
      logic [ADDR_W-1:0]  address;
      logic [SIZE_W-1:0]  size;
      logic [CU_ID_W-1:0] cu_id;
   } command_buffer_line_t;

   typedef struct packed {
      logic                 valid;
      command_buffer_line_t cmd;
      logic [DATA_W-1:0]    data;
   } read_write_data_line_t;

   typedef struct packed {
      logic               valid;
      logic [RESP_W-1:0]  response;
      logic [CU_ID_W-1:0] cu_id;
   } response_buffer_line_t;

   typedef struct packed {
      logic alfull;
      logic full;
      logic empty;
   } buffer_status_t;

   typedef struct packed {
      logic [ADDR_W-1:0] src_address;
      logic [DATA_W-1:0] data_0;
      logic [DATA_W-1:0] data_1;
   } line_entry_t;

   localparam logic [ARRAY_SIZE_BITS:0] ELEMS_ROUND = (ARRAY_SIZE_BITS+1)'(ELEMS_PER_LINE - 1);

   // Number of 128B lines covering 'elems' 4B elements; one extra bit keeps
   // the round-up add from wrapping at the top of the range.
   function automatic logic [ARRAY_SIZE_BITS-1:0] lines_for_size(input logic [ARRAY_SIZE_BITS-1:0] elems);
      logic [ARRAY_SIZE_BITS:0] sum;
      sum = {1'b0, elems} + ELEMS_ROUND;
      return ARRAY_SIZE_BITS'(sum >> LINE_SHIFT);
   endfunction

endpackage

// File: rtl/write_line_fifo.sv
// write_line_fifo
// Synchronous show-ahead FIFO of paired cache lines {src_address, data_0, data_1}.
// Ports:
//   clock, rstn      rising-edge clock, synchronous active-high reset
//   push, push_data  enqueue one line (dropped when full)
//   pop              dequeue head (ignored when empty)
//   head             current head entry, valid whenever status.empty == 0
//   status           empty / full / alfull (alfull at DEPTH-2 entries)
module write_line_fifo
   import write_engine_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic           clock,
   input  logic           rstn,
   input  logic           push,
   input  line_entry_t    push_data,
   input  logic           pop,
   output line_entry_t    head,
   output buffer_status_t status
);

   localparam int PTR_W = $clog2(DEPTH);

   line_entry_t       mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W:0]    count;
   logic              do_push;
   logic              do_pop;

   assign status.empty  = (count == '0);
   assign status.full   = (count == (PTR_W+1)'(DEPTH));
   assign status.alfull = (count >= (PTR_W+1)'(DEPTH - 2));

   assign do_push = push && !status.full;
   assign do_pop  = pop && !status.empty;
   assign head    = mem[rd_ptr];

   // Storage kept out of reset so it maps onto plain RAM.
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clock) begin
      if (rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   a_push_full: assert property (@(posedge clock) disable iff (rstn) !(push && status.full));

endmodule

// File: rtl/write_engine.sv
// write_engine
// Pairs returned read half-lines into 128B lines, stages them in a FIFO and
// issues one WRITE_MI command plus both data halves per line. Counts DONE
// write responses into the job-done counter.
// Ports:
//   clock, rstn                   rising-edge clock, synchronous active-high reset
//   write_enabled_in              start / continue issue
//   wed_request_in                job descriptor (bases, element count)
//   read_data_0_in/1_in           returned half 0 / half 1 of a source line
//   write_response_in             write response stream
//   write_command_buffer_status   .alfull stalls issue
//   write_data_buffer_status      .alfull stalls issue
//   write_command_out             WRITE_MI command, one-cycle valid per line
//   write_data_0_out/1_out        data halves, same cycle as the command
//   line_buffer_status_out        staging FIFO status (read-side backpressure)
//   write_job_counter_done        lines acknowledged with DONE
module write_engine
   import write_engine_pkg::*;
#(
   parameter logic [CU_ID_W-1:0] CU_WRITE_CONTROL_ID = DATA_WRITE_CONTROL_ID,
   parameter int                 LINE_FIFO_DEPTH     = 16,
   parameter int                 MAX_OUTSTANDING     = 32
) (
   input  logic                       clock,
   input  logic                       rstn,
   input  logic                       write_enabled_in,
   input  wed_interface_t             wed_request_in,
   input  read_write_data_line_t      read_data_0_in,
   input  read_write_data_line_t      read_data_1_in,
   input  response_buffer_line_t      write_response_in,
   input  buffer_status_t             write_command_buffer_status,
   input  buffer_status_t             write_data_buffer_status,
   output command_buffer_line_t       write_command_out,
   output read_write_data_line_t      write_data_0_out,
   output read_write_data_line_t      write_data_1_out,
   output buffer_status_t             line_buffer_status_out,
   output logic [ARRAY_SIZE_BITS-1:0] write_job_counter_done
);

   localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

   write_engine_state_t        state, state_nxt;
   logic [ADDR_W-1:0]          array_send_q, array_receive_q;
   logic [ARRAY_SIZE_BITS-1:0] size_send_q, total_lines, issued, done_cnt;
   logic [OUT_W-1:0]           outstanding;

   logic                       h0_vld;
   logic [ADDR_W-1:0]          h0_addr;
   logic [DATA_W-1:0]          h0_data;
   logic                       pair_fire, pair_vld;
   line_entry_t                pair_q;

   line_entry_t                fifo_head;
   buffer_status_t             fifo_status;
   logic                       start, issue, resp_done;
   logic [ADDR_W-1:0]          dst_address;
   command_buffer_line_t       cmd_nxt;

   // ---------------------------------------------------------------- pairing
   // Half 1 completes a line with the held half 0 if there is one, otherwise
   // with a half 0 arriving alongside it. A half 0 that is not consumed this
   // cycle (including the next line's half 0 next to a held pair) is held.
   assign pair_fire = read_data_1_in.valid && (h0_vld || read_data_0_in.valid);

   always_ff @(posedge clock) begin
      if (rstn) begin
         h0_vld   <= 1'b0;
         h0_addr  <= '0;
         h0_data  <= '0;
         pair_vld <= 1'b0;
         pair_q   <= '0;
      end else begin
         pair_vld <= pair_fire;
         if (pair_fire) begin
            pair_q.src_address <= h0_vld ? h0_addr : read_data_0_in.cmd.address;
            pair_q.data_0      <= h0_vld ? h0_data : read_data_0_in.data;
            pair_q.data_1      <= read_data_1_in.data;
         end
         if (read_data_0_in.valid && !(read_data_1_in.valid && !h0_vld)) begin
            h0_vld  <= 1'b1;
            h0_addr <= read_data_0_in.cmd.address;
            h0_data <= read_data_0_in.data;
         end else if (read_data_1_in.valid) begin
            h0_vld  <= 1'b0;
         end
      end
   end

   a_half0_overwrite: assert property (@(posedge clock) disable iff (rstn)
      !(read_data_0_in.valid && !read_data_1_in.valid && h0_vld));

   write_line_fifo #(.DEPTH(LINE_FIFO_DEPTH)) u_fifo (
      .clock     (clock),
      .rstn      (rstn),
      .push      (pair_vld),
      .push_data (pair_q),
      .pop       (issue),
      .head      (fifo_head),
      .status    (fifo_status)
   );

   assign line_buffer_status_out = fifo_status;

   // ---------------------------------------------------------------- issue
   assign start     = (state == IDLE) && wed_request_in.valid && write_enabled_in;
   assign issue     = (state == STREAM) && !fifo_status.empty
                      && !write_command_buffer_status.alfull && !write_data_buffer_status.alfull
                      && (outstanding < OUT_W'(MAX_OUTSTANDING)) && write_enabled_in
                      && (issued != total_lines);
   // Responses outside an active job (e.g. stragglers after a reset) are ignored.
   assign resp_done = write_response_in.valid && (write_response_in.response == RSP_DONE)
                      && ((state == STREAM) || (state == DRAIN));

   assign dst_address = (array_receive_q + (fifo_head.src_address - array_send_q))
                        & ~ADDR_W'(CACHELINE_BYTES - 1);

   always_comb begin
      cmd_nxt         = '0;
      cmd_nxt.valid   = 1'b1;
      cmd_nxt.command = WRITE_MI;
      cmd_nxt.address = dst_address;
      cmd_nxt.size    = SIZE_W'(CACHELINE_BYTES);
      cmd_nxt.cu_id   = CU_WRITE_CONTROL_ID;
   end

   always_ff @(posedge clock) begin
      if (rstn) begin
         write_command_out <= '0;
         write_data_0_out  <= '0;
         write_data_1_out  <= '0;
      end else begin
         write_command_out.valid <= issue;
         write_data_0_out.valid  <= issue;
         write_data_1_out.valid  <= issue;
         if (issue) begin
            write_command_out     <= cmd_nxt;
            write_data_0_out.cmd  <= cmd_nxt;
            write_data_0_out.data <= fifo_head.data_0;
            write_data_1_out.cmd  <= cmd_nxt;
            write_data_1_out.data <= fifo_head.data_1;
         end
      end
   end

   // ---------------------------------------------------------------- FSM
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = SETUP;
         SETUP:   state_nxt = (lines_for_size(size_send_q) == '0) ? DONE : STREAM;
         STREAM:  if (issued == total_lines) state_nxt = DRAIN;
         DRAIN:   if (done_cnt == total_lines) state_nxt = DONE;
         DONE:    state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (rstn) begin
         state           <= IDLE;
         array_send_q    <= '0;
         array_receive_q <= '0;
         size_send_q     <= '0;
         total_lines     <= '0;
         issued          <= '0;
         done_cnt        <= '0;
         outstanding     <= '0;
      end else begin
         state <= state_nxt;
         if (start) begin
            array_send_q    <= wed_request_in.array_send;
            array_receive_q <= wed_request_in.array_receive;
            size_send_q     <= wed_request_in.size_send;
         end
         if (state == SETUP) begin
            total_lines <= lines_for_size(size_send_q);
            issued      <= '0;
            done_cnt    <= '0;
            outstanding <= '0;
         end else begin
            if (issue)     issued   <= issued + 1'b1;
            if (resp_done) done_cnt <= done_cnt + 1'b1;
            case ({issue, resp_done})
               2'b10:   outstanding <= outstanding + 1'b1;
               2'b01:   if (outstanding != '0) outstanding <= outstanding - 1'b1;
               default: outstanding <= outstanding;
            endcase
         end
      end
   end

   assign write_job_counter_done = done_cnt;

   logic unused_inputs;
   assign unused_inputs = ^{read_data_0_in.cmd, read_data_1_in.cmd, write_response_in.cu_id,
                            write_command_buffer_status.full, write_command_buffer_status.empty,
                            write_data_buffer_status.full, write_data_buffer_status.empty};

endmodule

// File: tb/tb_write_engine.sv
module tb_write_engine;
   import write_engine_pkg::*;

   logic                       clock;
   logic                       rstn;
   logic                       write_enabled_in;
   wed_interface_t             wed;
   read_write_data_line_t      rd0, rd1;
   response_buffer_line_t      resp;
   buffer_status_t             cmd_bs, data_bs;

   command_buffer_line_t       cmd1, cmd2, mon_cmd;
   read_write_data_line_t      d0o1, d1o1, d0o2, d1o2, mon_d0, mon_d1;
   buffer_status_t             st1, st2, mon_st;
   logic [ARRAY_SIZE_BITS-1:0] done1, done2, mon_done;
   logic                       sel;   // 0: default DUT, 1: MAX_OUTSTANDING=2 DUT

   typedef struct {
      logic [ADDR_W-1:0] dst;
      logic [ADDR_W-1:0] src;
   } exp_t;
   exp_t exp_q[$];

   int n_checks = 0;
   int n_errors = 0;
   int cmd_seen = 0;
   int cyc      = 0;
   int first_cyc = -1;
   int last_cyc  = -1;

   write_engine dut (
      .clock(clock), .rstn(rstn), .write_enabled_in(write_enabled_in),
      .wed_request_in(wed), .read_data_0_in(rd0), .read_data_1_in(rd1),
      .write_response_in(resp), .write_command_buffer_status(cmd_bs),
      .write_data_buffer_status(data_bs), .write_command_out(cmd1),
      .write_data_0_out(d0o1), .write_data_1_out(d1o1),
      .line_buffer_status_out(st1), .write_job_counter_done(done1)
   );

   write_engine #(.MAX_OUTSTANDING(2)) dut2 (
      .clock(clock), .rstn(rstn), .write_enabled_in(write_enabled_in),
      .wed_request_in(wed), .read_data_0_in(rd0), .read_data_1_in(rd1),
      .write_response_in(resp), .write_command_buffer_status(cmd_bs),
      .write_data_buffer_status(data_bs), .write_command_out(cmd2),
      .write_data_0_out(d0o2), .write_data_1_out(d1o2),
      .line_buffer_status_out(st2), .write_job_counter_done(done2)
   );

   assign mon_cmd  = sel ? cmd2  : cmd1;
   assign mon_d0   = sel ? d0o2  : d0o1;
   assign mon_d1   = sel ? d1o2  : d1o1;
   assign mon_st   = sel ? st2   : st1;
   assign mon_done = sel ? done2 : done1;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [DATA_W-1:0] mk_data(input logic [ADDR_W-1:0] a, input logic h);
      logic [ADDR_W-1:0] w;
      w = a ^ (h ? 64'hA5A5_0000_1111_FFFF : 64'h0123_4567_89AB_CDEF);
      return {8{w}};
   endfunction

   task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock); #1;
   endtask

   task automatic expect_line(input logic [ADDR_W-1:0] src, input logic [ADDR_W-1:0] dst);
      exp_t e;
      e.src = src;
      e.dst = dst;
      exp_q.push_back(e);
   endtask

   task automatic drive_halves(input logic v0, input logic [ADDR_W-1:0] a0,
                               input logic v1, input logic [ADDR_W-1:0] a1);
      rd0 = '0;
      rd1 = '0;
      rd0.valid = v0; rd0.cmd.address = a0; rd0.data = mk_data(a0, 1'b0);
      rd1.valid = v1; rd1.cmd.address = a1; rd1.data = mk_data(a1, 1'b1);
      tick();
      rd0 = '0;
      rd1 = '0;
   endtask

   task automatic send_same(input logic [ADDR_W-1:0] src, input logic [ADDR_W-1:0] dst);
      expect_line(src, dst);
      drive_halves(1'b1, src, 1'b1, src);
   endtask

   task automatic send_resp(input logic [RESP_W-1:0] code);
      resp = '0;
      resp.valid = 1'b1;
      resp.response = code;
      resp.cu_id = DATA_WRITE_CONTROL_ID;
      tick();
      resp = '0;
   endtask

   task automatic do_reset();
      rstn = 1'b1;
      tick(); tick();
      rstn = 1'b0;
      exp_q.delete();
      cmd_seen  = 0;
      first_cyc = -1;
      last_cyc  = -1;
   endtask

   task automatic start_job(input logic [ADDR_W-1:0] snd, input logic [ADDR_W-1:0] rcv,
                            input logic [ARRAY_SIZE_BITS-1:0] sz);
      wed.valid = 1'b1; wed.array_send = snd; wed.array_receive = rcv; wed.size_send = sz;
      tick();
      wed.valid = 1'b0;
   endtask

   task automatic wait_cmds(input int n, input int budget, input string name);
      int k = 0;
      while (cmd_seen < n && k < budget) begin
         tick();
         k++;
      end
      check(name, DATA_W'(cmd_seen), DATA_W'(n));
   endtask

   // Scoreboard monitor: every presented command is matched against the
   // oldest expected line.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         cyc++;
         if (mon_cmd.valid) begin
            cmd_seen++;
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
            if (exp_q.size() == 0) begin
               check("unexpected_cmd", DATA_W'(mon_cmd.address), DATA_W'(0));
            end else begin
               e = exp_q.pop_front();
               check("cmd_address", DATA_W'(mon_cmd.address), DATA_W'(e.dst));
               check("cmd_opcode",  DATA_W'(mon_cmd.command), DATA_W'(WRITE_MI));
               check("cmd_size",    DATA_W'(mon_cmd.size),    DATA_W'(128));
               check("cmd_cu_id",   DATA_W'(mon_cmd.cu_id),   DATA_W'(DATA_WRITE_CONTROL_ID));
               check("data_valids", DATA_W'({mon_d0.valid, mon_d1.valid}), DATA_W'(2'b11));
               check("data_0",      mon_d0.data, mk_data(e.src, 1'b0));
               check("data_1",      mon_d1.data, mk_data(e.src, 1'b1));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rstn = 1'b1; write_enabled_in = 1'b1; sel = 1'b0;
      wed = '0; rd0 = '0; rd1 = '0; resp = '0; cmd_bs = '0; data_bs = '0;

      // reset state
      do_reset();
      check("rst_cmd_valid",  DATA_W'(cmd1.valid), DATA_W'(0));
      check("rst_d_valids",   DATA_W'({d0o1.valid, d1o1.valid}), DATA_W'(0));
      check("rst_done",       DATA_W'(done1), DATA_W'(0));
      check("rst_fifo_stat",  DATA_W'({st1.alfull, st1.full, st1.empty}), DATA_W'(3'b001));
      check("rst_state",      DATA_W'(dut.state), DATA_W'(IDLE));

      // 1: two lines, halves together
      start_job(64'h1000, 64'h8000, 32'd64);
      send_same(64'h1000, 64'h8000);
      send_same(64'h1080, 64'h8080);
      wait_cmds(2, 20, "t1_cmds");
      send_resp(RSP_DONE);
      send_resp(RSP_DONE);
      tick(); tick();
      check("t1_done",  DATA_W'(done1), DATA_W'(2));
      check("t1_state", DATA_W'(dut.state), DATA_W'(DONE));
      send_resp(RSP_DONE);
      tick();
      check("t1_done_stable", DATA_W'(done1), DATA_W'(2));

      // 2: next line's half 0 alongside the current half 1
      do_reset();
      start_job(64'h3000, 64'h20000, 32'd96);
      expect_line(64'h3000, 64'h20000);
      expect_line(64'h3080, 64'h20080);
      expect_line(64'h3100, 64'h20100);
      drive_halves(1'b1, 64'h3000, 1'b0, 64'h0);
      drive_halves(1'b1, 64'h3080, 1'b1, 64'h3000);
      drive_halves(1'b1, 64'h3100, 1'b1, 64'h3080);
      drive_halves(1'b0, 64'h0,    1'b1, 64'h3100);
      wait_cmds(3, 20, "t2_cmds");
      repeat (3) send_resp(RSP_DONE);
      tick(); tick();
      check("t2_done",  DATA_W'(done1), DATA_W'(3));
      check("t2_state", DATA_W'(dut.state), DATA_W'(DONE));

      // 3: command buffer almost-full for 20 cycles with 4 lines queued
      do_reset();
      cmd_bs.alfull = 1'b1;
      start_job(64'h5000, 64'h9000, 32'd128);
      for (int i = 0; i < 4; i++) send_same(64'h5000 + 64'(i) * 64'h80, 64'h9000 + 64'(i) * 64'h80);
      repeat (15) tick();
      check("t3_hold_no_cmd",   DATA_W'(cmd_seen), DATA_W'(0));
      check("t3_fifo_nonempty", DATA_W'({st1.alfull, st1.empty}), DATA_W'(2'b00));
      cmd_bs.alfull = 1'b0;
      wait_cmds(4, 20, "t3_cmds");
      check("t3_back_to_back", DATA_W'(last_cyc - first_cyc), DATA_W'(3));
      repeat (4) send_resp(RSP_DONE);
      tick(); tick();
      check("t3_done", DATA_W'(done1), DATA_W'(4));

      // 4: outstanding limit of 2, 5 lines, responses withheld
      sel = 1'b1;
      do_reset();
      start_job(64'h2000, 64'hA000, 32'd160);
      for (int i = 0; i < 5; i++) send_same(64'h2000 + 64'(i) * 64'h80, 64'hA000 + 64'(i) * 64'h80);
      repeat (15) tick();
      check("t4_limit", DATA_W'(cmd_seen), DATA_W'(2));
      send_resp(RSP_FAILED);
      repeat (4) tick();
      check("t4_failed_no_free", DATA_W'(cmd_seen), DATA_W'(2));
      check("t4_failed_no_done", DATA_W'(done2), DATA_W'(0));
      for (int k = 1; k <= 5; k++) begin
         send_resp(RSP_DONE);
         repeat (4) tick();
         check("t4_release", DATA_W'(cmd_seen), DATA_W'((k + 2 > 5) ? 5 : k + 2));
      end
      check("t4_done",  DATA_W'(done2), DATA_W'(5));
      check("t4_state", DATA_W'(dut2.state), DATA_W'(DONE));
      sel = 1'b0;

      // 5: empty job
      do_reset();
      start_job(64'h0, 64'h0, 32'd0);
      repeat (4) tick();
      check("t5_state",  DATA_W'(dut.state), DATA_W'(DONE));
      check("t5_no_cmd", DATA_W'(cmd_seen), DATA_W'(0));
      check("t5_done",   DATA_W'(done1), DATA_W'(0));

      // 6: almost-full threshold at 14 staged lines
      do_reset();
      cmd_bs.alfull = 1'b1;
      start_job(64'h6000, 64'h40000, 32'd448);
      for (int i = 0; i < 13; i++) send_same(64'h6000 + 64'(i) * 64'h80, 64'h40000 + 64'(i) * 64'h80);
      tick(); tick();
      check("t6_13_not_alfull", DATA_W'({st1.alfull, st1.full}), DATA_W'(2'b00));
      send_same(64'h6000 + 64'd13 * 64'h80, 64'h40000 + 64'd13 * 64'h80);
      tick(); tick();
      check("t6_14_alfull", DATA_W'({st1.alfull, st1.full}), DATA_W'(2'b10));
      cmd_bs.alfull = 1'b0;
      wait_cmds(14, 40, "t6_cmds");

      // 7: reset mid-stream with 3 outstanding
      do_reset();
      start_job(64'h4000, 64'h100000, 32'd320);
      for (int i = 0; i < 3; i++) send_same(64'h4000 + 64'(i) * 64'h80, 64'h100000 + 64'(i) * 64'h80);
      wait_cmds(3, 20, "t7_cmds");
      rstn = 1'b1;
      tick();
      check("t7_rst_valids", DATA_W'({cmd1.valid, d0o1.valid, d1o1.valid}), DATA_W'(0));
      check("t7_rst_fifo",   DATA_W'({st1.alfull, st1.full, st1.empty}), DATA_W'(3'b001));
      check("t7_rst_state",  DATA_W'(dut.state), DATA_W'(IDLE));
      rstn = 1'b0;
      repeat (3) send_resp(RSP_DONE);
      tick();
      check("t7_late_resp", DATA_W'(done1), DATA_W'(0));

      check("exp_queue_drained", DATA_W'(exp_q.size()), DATA_W'(0));
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
